spi_master_multi: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit single-slave master. Adds configurable word width, clock divider, per-transfer SPI mode (CPOL/CPHA), multiple active-low slave selects and full-duplex receive with a valid strobe. Sits between the AHB-side control logic and the off-chip SPI pins. One word per start handshake.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_master_multi.sv | 150 +++++++++++++++
 tb/tb_spi_master_multi.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
// Imported by the divider and the top level.
package spi_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StXfer,
        StHold
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Deasserted level of every active-low slave select.
    localparam logic SsInactive = 1'b1;
    localparam int unsigned MinClkDiv = 1;

    // Width of a select index; a single slave still gets a 1-bit port.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI half-period divider: one-cycle tick every CLK_DIV cycles while not cleared.
// The counter restarts from zero on the cycle after clear drops.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] Term = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i || (cnt_q == Term)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign tick_o = !clear_i && (cnt_q == Term);

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: configurable width, divider, per-transfer CPOL/CPHA,
// active-low slave selects and full-duplex receive with a one-cycle valid strobe.
module spi_master_multi
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_SS    = 4,
    parameter int unsigned CLK_DIV   = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [DATA_W-1:0]            tx_data_i,
    input  logic [sel_width(NUM_SS)-1:0] ss_sel_i,
    input  logic                         cpol_i,
    input  logic                         cpha_i,
    output logic                         ready_o,
    output logic [DATA_W-1:0]            rx_data_o,
    output logic                         rx_valid_o,
    output logic                         spi_clk_o,
    output logic                         spi_mosi_o,
    input  logic                         spi_miso_i,
    output logic [NUM_SS-1:0]            spi_ss_o
);

    localparam int unsigned SelW     = sel_width(NUM_SS);
    localparam int unsigned DivEff   = (CLK_DIV < MinClkDiv) ? MinClkDiv : CLK_DIV;
    localparam int unsigned Edges    = 2 * DATA_W;
    localparam int unsigned EdgeW    = $clog2(Edges + 1);
    localparam logic [EdgeW-1:0] LastEdge = EdgeW'(Edges - 1);

    spi_state_t        state_q, state_d;
    spi_mode_t         mode_q;
    logic [SelW-1:0]   sel_q;
    logic [EdgeW-1:0]  edge_cnt_q;
    logic [DATA_W-1:0] tx_shift_q, rx_shift_q, rx_data_q;
    logic              rx_valid_q, sclk_q, mosi_q;
    logic              tick, div_clear, accept, last_edge, leading, shift_out, sample;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign div_clear = (state_q == StIdle);

    spi_clk_div #(
        .CLK_DIV(DivEff)
    ) u_clk_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clear_i(div_clear),
        .tick_o (tick)
    );

    assign accept    = (state_q == StIdle) && start_i;
    assign last_edge = (edge_cnt_q == LastEdge);
    // Toggles done so far is even, so the pending toggle is a leading edge.
    assign leading   = ~edge_cnt_q[0];
    assign shift_out = (state_q == StXfer) && tick &&
                       (mode_q.cpha ? leading : (!leading && !last_edge));
    assign sample    = (state_q == StXfer) && tick && (mode_q.cpha ? !leading : leading);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StSetup;
            StSetup: if (tick) state_d = StXfer;
            StXfer:  if (tick && last_edge) state_d = StHold;
            StHold:  if (tick) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_o  = (state_q == StIdle);
        spi_ss_o = {NUM_SS{SsInactive}};
        // An out-of-range select matches no line, so the transfer runs unselected.
        for (int unsigned i = 0; i < NUM_SS; i++) begin
            if ((state_q != StIdle) && (32'(sel_q) == i)) begin
                spi_ss_o[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q     <= '0;
            sel_q      <= '0;
            edge_cnt_q <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (accept) begin
                mode_q.cpol <= cpol_i;
                mode_q.cpha <= cpha_i;
                sel_q       <= ss_sel_i;
                edge_cnt_q  <= '0;
                sclk_q      <= cpol_i;
                rx_shift_q  <= '0;
                if (cpha_i) begin
                    tx_shift_q <= tx_data_i;
                end else begin
                    mosi_q     <= first_bit(tx_data_i);
                    tx_shift_q <= shift_tx(tx_data_i);
                end
            end
            if ((state_q == StXfer) && tick) begin
                sclk_q     <= ~sclk_q;
                edge_cnt_q <= edge_cnt_q + EdgeW'(1);
            end
            if (shift_out) begin
                mosi_q     <= first_bit(tx_shift_q);
                tx_shift_q <= shift_tx(tx_shift_q);
            end
            if (sample) begin
                rx_shift_q <= MSB_FIRST ? {rx_shift_q[DATA_W-2:0], spi_miso_i}
                                        : {spi_miso_i, rx_shift_q[DATA_W-1:1]};
            end
            if ((state_q == StHold) && tick) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                mosi_q     <= 1'b0;
            end
        end
    end

    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Bench for spi_master_multi: two instances (MSB-first and LSB-first) share stimulus and
// are compared every cycle against a timeline model, plus directed literal checks.
module tb_spi_master_multi;

    localparam int W        = 8;
    localparam int NSS      = 3;
    localparam int DIV      = 2;
    localparam int XFER_LEN = DIV * (2 * W + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [W-1:0] tx = '0;
    logic [1:0] sel = '0;
    logic cpol = 1'b0, cpha = 1'b0;
    // 0: loopback, 1: inverted loopback, 2: MISO tied 0, 3: MISO tied 1
    logic [1:0] miso_mode = 2'd0;

    logic ready_a, rx_valid_a, sclk_a, mosi_a, miso_a;
    logic ready_b, rx_valid_b, sclk_b, mosi_b, miso_b;
    logic [W-1:0] rx_a, rx_b;
    logic [NSS-1:0] ss_a, ss_b;

    assign miso_a = miso_mode[1] ? miso_mode[0] : (mosi_a ^ miso_mode[0]);
    assign miso_b = miso_mode[1] ? miso_mode[0] : (mosi_b ^ miso_mode[0]);

    always #5 clk = ~clk;

    spi_master_multi #(
        .DATA_W(W), .NUM_SS(NSS), .CLK_DIV(DIV), .MSB_FIRST(1'b1)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx), .ss_sel_i(sel),
        .cpol_i(cpol), .cpha_i(cpha), .ready_o(ready_a), .rx_data_o(rx_a),
        .rx_valid_o(rx_valid_a), .spi_clk_o(sclk_a), .spi_mosi_o(mosi_a),
        .spi_miso_i(miso_a), .spi_ss_o(ss_a)
    );

    spi_master_multi #(
        .DATA_W(W), .NUM_SS(NSS), .CLK_DIV(DIV), .MSB_FIRST(1'b0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start), .tx_data_i(tx), .ss_sel_i(sel),
        .cpol_i(cpol), .cpha_i(cpha), .ready_o(ready_b), .rx_data_o(rx_b),
        .rx_valid_o(rx_valid_b), .spi_clk_o(sclk_b), .spi_mosi_o(mosi_b),
        .spi_miso_i(miso_b), .spi_ss_o(ss_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_rx(input logic [W-1:0] d, input logic [1:0] mm);
        case (mm)
            2'd0:    return d;
            2'd1:    return ~d;
            2'd2:    return '0;
            default: return '1;
        endcase
    endfunction

    // SCK toggles completed t cycles after the accept edge.
    function automatic int toggles(input int t);
        int k;
        k = t / DIV - 1;
        if (k < 0) k = 0;
        if (k > 2 * W) k = 2 * W;
        return k;
    endfunction

    // Timeline model: accept time, latched request and the word the slave side returns.
    logic m_busy, m_cpol, m_cpha, m_valid;
    int m_t;
    logic [W-1:0] m_tx, m_rx;
    logic [1:0] m_sel, m_mode;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_t <= 0; m_tx <= '0; m_sel <= '0; m_cpol <= 1'b0;
            m_cpha <= 1'b0; m_mode <= '0; m_valid <= 1'b0; m_rx <= '0;
        end else begin
            m_valid <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1; m_t <= 0; m_tx <= tx; m_sel <= sel;
                    m_cpol <= cpol; m_cpha <= cpha; m_mode <= miso_mode;
                end
            end else if (m_t + 1 == XFER_LEN) begin
                m_busy <= 1'b0; m_valid <= 1'b1; m_rx <= exp_rx(m_tx, m_mode);
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge clk) begin : cmp
        int k;
        int j;
        logic [NSS-1:0] e_ss;
        logic e_sclk, e_mosi_a, e_mosi_b;
        if (!rst) begin
            k = toggles(m_t);
            e_ss = '1;
            if (m_busy && (m_sel < NSS)) e_ss[m_sel] = 1'b0;
            e_sclk = m_busy ? (m_cpol ^ k[0]) : m_cpol;
            e_mosi_a = 1'b0;
            e_mosi_b = 1'b0;
            if (m_busy && (!m_cpha || k > 0)) begin
                j = m_cpha ? (k + 1) / 2 - 1 : k / 2;
                if (j > W - 1) j = W - 1;
                e_mosi_a = m_tx[W-1-j];
                e_mosi_b = m_tx[j];
            end
            check("cycle_a", 32'({ready_a, ss_a, sclk_a, mosi_a, rx_valid_a, rx_a}),
                  32'({!m_busy, e_ss, e_sclk, e_mosi_a, m_valid, m_rx}));
            check("cycle_b", 32'({ready_b, ss_b, sclk_b, mosi_b, rx_valid_b, rx_b}),
                  32'({!m_busy, e_ss, e_sclk, e_mosi_b, m_valid, m_rx}));
        end
    end

    int rise_a = 0;
    logic [W-1:0] cap_a = '0, cap_b = '0;
    int vcount = 0;
    always @(posedge sclk_a) begin
        rise_a <= rise_a + 1;
        cap_a  <= {cap_a[W-2:0], mosi_a};
    end
    always @(posedge sclk_b) cap_b <= {cap_b[W-2:0], mosi_b};
    always @(posedge clk) if (rx_valid_a) vcount <= vcount + 1;

    task automatic launch(input logic [W-1:0] d, input logic [1:0] s, input logic p,
                          input logic h, input logic [1:0] mm);
        @(negedge clk);
        tx = d; sel = s; cpol = p; cpha = h; miso_mode = mm; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!rx_valid_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid_a) check("valid_timeout", 32'(n), 32'(XFER_LEN));
    endtask

    int n, r0, v0;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", 32'({ready_a, ss_a, sclk_a, mosi_a, rx_valid_a, rx_a}),
              32'({1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 8'h00}));

        // Mode 0 loopback of 0x69.
        r0 = rise_a;
        launch(8'h69, 2'd0, 1'b0, 1'b0, 2'd0);
        check("m0_ss_at_t0", 32'(ss_a), 32'(3'b110));
        wait_valid(n);
        check("m0_latency", 32'(n), 32'd36);
        check("m0_rx", 32'(rx_a), 32'h69);
        check("m0_rises", 32'(rise_a - r0), 32'd8);
        check("m0_mosi_msb", 32'(cap_a), 32'h69);
        check("m0_mosi_lsb", 32'(cap_b), 32'h96);

        // Mode 3, MISO tied high.
        launch(8'hA5, 2'd1, 1'b1, 1'b1, 2'd3);
        wait_valid(n);
        check("m3_rx_a", 32'(rx_a), 32'hFF);
        check("m3_rx_b", 32'(rx_b), 32'hFF);
        check("m3_mosi_lsb", 32'(cap_b), 32'hA5);
        check("m3_sclk_idle", 32'(sclk_a), 32'd1);

        // Reset after the third SCK edge.
        launch(8'h5A, 2'd2, 1'b0, 1'b0, 2'd0);
        repeat (9) @(negedge clk);
        v0 = vcount;
        #2 rst = 1'b1;
        #1 check("rst_outputs", 32'({ready_a, ss_a, sclk_a, mosi_a, rx_valid_a, rx_a}),
                 32'({1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 8'h00}));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        launch(8'h3C, 2'd2, 1'b0, 1'b0, 2'd0);
        wait_valid(n);
        check("rst_next_rx", 32'(rx_a), 32'h3C);
        @(negedge clk);
        check("rst_one_pulse", 32'(vcount - v0), 32'd1);

        // Back-to-back with start held high.
        @(negedge clk);
        v0 = vcount;
        tx = 8'h12; sel = 2'd0; cpol = 1'b0; cpha = 1'b0; miso_mode = 2'd0; start = 1'b1;
        @(negedge clk);
        wait_valid(n);
        tx = 8'h34;
        check("b2b_rx0", 32'(rx_a), 32'h12);
        check("b2b_gap_ss", 32'(ss_a), 32'(3'b111));
        @(negedge clk);
        start = 1'b0;
        check("b2b_second_sel", 32'({ready_a, ss_a}), 32'({1'b0, 3'b110}));
        wait_valid(n);
        check("b2b_rx1", 32'(rx_a), 32'h34);
        @(negedge clk);
        check("b2b_pulses", 32'(vcount - v0), 32'd2);

        // Random traffic, including busy-time starts and input changes.
        v0 = vcount;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            tx    = 8'($urandom);
            sel   = 2'($urandom);
            cpol  = 1'($urandom);
            cpha  = 1'($urandom);
            if (!m_busy) miso_mode = 2'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && m_busy; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("rand_idle", 32'(ready_a), 32'd1);
        check("rand_activity", 32'(vcount - v0 > 20), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
